// File: rtl/pht_pkg.sv
// Shared types and helpers for the gshare pattern history table: FSM states,
// counter bounds and the saturating-counter step function.
package pht_pkg;

  typedef enum logic [0:0] {
    PHT_INIT = 1'b0,
    PHT_RUN  = 1'b1
  } pht_state_e;

  localparam int                        PHT_CTR_W_MAX = 4;
  localparam logic [PHT_CTR_W_MAX-1:0]  PHT_CTR_MIN   = 4'd0;

  // Largest value of a ctr_w-bit counter, held in the widest supported width.
  function automatic logic [PHT_CTR_W_MAX-1:0] pht_ctr_max(input int ctr_w);
    logic [PHT_CTR_W_MAX:0] span;
    span = 5'd1 << ctr_w;
    return 4'(span - 5'd1);
  endfunction

  // One training step of a saturating counter; never wraps at either end.
  function automatic logic [PHT_CTR_W_MAX-1:0] sat_next(
    input logic [PHT_CTR_W_MAX-1:0] cur,
    input logic                     taken,
    input int                       ctr_w
  );
    logic [PHT_CTR_W_MAX-1:0] nxt;
    if (taken) begin
      if (cur != pht_ctr_max(ctr_w)) nxt = cur + 4'd1;
      else                           nxt = cur;
    end else begin
      if (cur != PHT_CTR_MIN) nxt = cur - 4'd1;
      else                    nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_sat_ctr.sv
// Combinational next-value of one saturating PHT counter, shared by the
// training write path and the collision bypass.
module pht_sat_ctr
  import pht_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  logic [PHT_CTR_W_MAX-1:0] cur_ext_s;

  // Widen to the helper's width, step, and narrow back.
  always_comb begin
    cur_ext_s              = '0;
    cur_ext_s[CTR_W-1:0]   = cur;
    nxt                    = CTR_W'(sat_next(cur_ext_s, taken, CTR_W));
  end

endmodule

// File: rtl/gshare_pht.sv
// gshare pattern history table with self-initialising INIT->RUN sequencer.
// Optional macro PHT_BYPASS_EN: a same-cycle update to the looked-up index is forwarded.
module gshare_pht
  import pht_pkg::*;
#(
  parameter int               IDX_W    = 8,
  parameter int               CTR_W    = 2,
  parameter int               HIST_W   = 8,
  parameter logic [CTR_W-1:0] INIT_VAL = {CTR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_addr,
  output logic              ready,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] ghr_out
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  pht_state_e        state_r, state_nxt_s;
  logic [IDX_W-1:0]  ptr_r;
  logic [CTR_W-1:0]  mem_r [DEPTH];
  logic [HIST_W-1:0] ghr_r, ghr_nxt_s;
  logic [IDX_W-1:0]  ghr_ext_s, req_idx_s, waddr_s;
  logic [CTR_W-1:0]  rd_ctr_s, upd_cur_s, upd_nxt_s, wdata_s, pred_src_s;
  logic              we_s, req_fire_s, upd_fire_s;
  logic              ready_r, pred_valid_r;
  logic [CTR_W-1:0]  pred_ctr_r;
  logic [IDX_W-1:0]  pred_idx_r;

  // History zero-extended to index width and folded into the request address.
  always_comb begin
    ghr_ext_s               = '0;
    ghr_ext_s[HIST_W-1:0]   = ghr_r;
    req_idx_s               = req_addr ^ ghr_ext_s;
  end

  if (HIST_W == 1) begin : g_ghr_one
    assign ghr_nxt_s = upd_taken;
  end else begin : g_ghr_shift
    assign ghr_nxt_s = {ghr_r[HIST_W-2:0], upd_taken};
  end

  assign rd_ctr_s  = mem_r[req_idx_s];
  assign upd_cur_s = mem_r[upd_idx];

  pht_sat_ctr #(.CTR_W(CTR_W)) u_sat (
    .cur   (upd_cur_s),
    .taken (upd_taken),
    .nxt   (upd_nxt_s)
  );

  // Sequencer next state plus write-port and accept steering.
  always_comb begin
    state_nxt_s = state_r;
    we_s        = 1'b0;
    waddr_s     = ptr_r;
    wdata_s     = INIT_VAL;
    req_fire_s  = 1'b0;
    upd_fire_s  = 1'b0;
    case (state_r)
      PHT_INIT: begin
        we_s = 1'b1;
        if (ptr_r == LAST_IDX) state_nxt_s = PHT_RUN;
        else                   state_nxt_s = PHT_INIT;
      end
      PHT_RUN: begin
        req_fire_s = req_valid;
        upd_fire_s = upd_valid;
        we_s       = upd_valid;
        waddr_s    = upd_idx;
        wdata_s    = upd_nxt_s;
      end
      default: state_nxt_s = PHT_INIT;
    endcase
  end

  // Prediction source: stored counter, or the freshly trained one on a collision.
  always_comb begin
    pred_src_s = rd_ctr_s;
`ifdef PHT_BYPASS_EN
    if (upd_fire_s && (upd_idx == req_idx_s)) pred_src_s = upd_nxt_s;
    else                                      pred_src_s = rd_ctr_s;
`endif
  end

  // Sequencer state, init pointer and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PHT_INIT;
      ptr_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == PHT_RUN);
      if (state_r == PHT_INIT) ptr_r <= ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Single shared write port; contents are rebuilt by the sequencer after reset.
  always_ff @(posedge clk) begin
    if (!rst && we_s) mem_r[waddr_s] <= wdata_s;
  end

  // Non-speculative global history, trained only by resolved branches.
  always_ff @(posedge clk) begin
    if (rst)             ghr_r <= '0;
    else if (upd_fire_s) ghr_r <= ghr_nxt_s;
  end

  // One-cycle lookup pipeline; results hold between accepted requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_r <= 1'b0;
      pred_ctr_r   <= '0;
      pred_idx_r   <= '0;
    end else begin
      pred_valid_r <= req_fire_s;
      if (req_fire_s) begin
        pred_ctr_r <= pred_src_s;
        pred_idx_r <= req_idx_s;
      end
    end
  end

  assign ready      = ready_r;
  assign pred_valid = pred_valid_r;
  assign pred_ctr   = pred_ctr_r;
  assign pred_taken = pred_ctr_r[CTR_W-1];
  assign pred_idx   = pred_idx_r;
  assign ghr_out    = ghr_r;

endmodule

// File: tb/tb_gshare_pht.sv
// Randomised scoreboard bench for gshare_pht against an array/arithmetic model.
module tb_gshare_pht;
  localparam int DEPTH = 256;
  localparam int CMAX  = 3;

  logic       clk = 1'b0;
  logic       rst, req_valid, upd_valid, upd_taken;
  logic       ready, pred_valid, pred_taken;
  logic [7:0] req_addr, upd_idx, pred_idx, ghr_out;
  logic [1:0] pred_ctr;

  gshare_pht dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .ready(ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .ghr_out(ghr_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model [DEPTH];
  int mghr;

  typedef struct { int idx; int ctr; } exp_t;
  exp_t sb [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented prediction must match the oldest expectation.
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pred", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pred_idx", int'(pred_idx), e.idx);
        check("pred_ctr", int'(pred_ctr), e.ctr);
        check("pred_taken", int'(pred_taken), e.ctr / 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = CMAX;
    mghr = 0;
  endtask

  // Issue one RUN-phase cycle; the model decides the expected prediction.
  task automatic drive(input bit rv, input int addr, input bit uv, input int ui, input bit ut);
    int idx, nv;
    req_valid = rv; req_addr = addr[7:0];
    upd_valid = uv; upd_idx = ui[7:0]; upd_taken = ut;
    idx = (addr ^ mghr) % DEPTH;
    nv  = model[ui];
    if (uv) begin
      if (ut && nv < CMAX) nv = nv + 1;
      else if (!ut && nv > 0) nv = nv - 1;
    end
    if (rv) begin
      exp_t e;
      e.idx = idx;
      e.ctr = model[idx];
`ifdef PHT_BYPASS_EN
      if (uv && ui == idx) e.ctr = nv;
`endif
      sb.push_back(e);
    end
    if (uv) begin
      model[ui] = nv;
      mghr = ((mghr * 2) + int'(ut)) % DEPTH;
    end
    step();
    check("ghr_out", int'(ghr_out), mghr);
  endtask

  task automatic idle();
    req_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    req_addr = 8'h00; upd_idx = 8'h00;
  endtask

  // Reset, then walk the init phase with inputs optionally held active.
  task automatic do_reset(input bit hold);
    int n;
    rst = 1'b1;
    req_valid = hold; upd_valid = hold; upd_taken = 1'b1;
    req_addr = 8'h33; upd_idx = 8'h44;
    step();
    check("rst_ready", int'(ready), 0);
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_pred_ctr", int'(pred_ctr), 0);
    check("rst_pred_idx", int'(pred_idx), 0);
    check("rst_pred_taken", int'(pred_taken), 0);
    check("rst_ghr", int'(ghr_out), 0);
    rst = 1'b0;
    n = 0;
    while (n < 400) begin
      step();
      n++;
      if (ghr_out !== 8'h00) check("init_ghr", int'(ghr_out), 0);
      if (ready === 1'b1) break;
    end
    idle();
    check("init_len", n, DEPTH);
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    step();
    // Init with req/upd held high: must be ignored.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, (i * 67) % DEPTH, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b1, 5, 1'b0);
    drive(1'b1, 5 ^ mghr, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b1, 5, 1'b1);
    drive(1'b1, 5 ^ mghr, 1'b0, 0, 1'b0);
    // History / index folding.
    do_reset(1'b0);
    drive(1'b0, 0, 1'b1, 20, 1'b1);
    drive(1'b0, 0, 1'b1, 21, 1'b0);
    drive(1'b0, 0, 1'b1, 22, 1'b1);
    check("ghr_101", int'(ghr_out), 5);
    drive(1'b1, 8'h0F, 1'b0, 0, 1'b0);
    // Collision on index 3.
    do_reset(1'b0);
    drive(1'b0, 0, 1'b1, 3, 1'b0);
    drive(1'b1, 3, 1'b1, 3, 1'b0);
    drive(1'b1, 3, 1'b0, 0, 1'b0);
    // Random traffic, narrow update range to provoke collisions.
    for (int i = 0; i < 500; i++) begin
      int a, u;
      a = int'($urandom_range(0, 255));
      u = ($urandom_range(0, 3) == 0) ? ((a ^ mghr) % DEPTH) : int'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), u, 1'($urandom_range(0, 1)));
    end
    // Reset the cycle after a request: in-flight result drops, table rebuilt.
    drive(1'b1, 8'h21, 1'b1, 7, 1'b1);
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 1'b0, 0, 1'b0);
    idle();
    step();
    step();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
